// File: rtl/vga_frame_reader.sv
// 640x480@60 scan of a centred 256x256 grayscale window read from the framebuffer's VGA port.
// Optional VGA_BORDER_EN draws a white 1-pixel ring around the image window.
module vga_frame_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int IMG_X       = 192,
    parameter int IMG_Y       = 112,
    parameter int ADDR_WIDTH  = 17,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            color,
    output logic [ADDR_WIDTH-1:0] address_vga,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_blank_n,
    output logic                  vga_sync_n,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_X0     = HW'(IMG_X);
    localparam logic [HW-1:0] IMG_X1     = HW'(IMG_X + IMG_W);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] IMG_Y0     = VW'(IMG_Y);
    localparam logic [VW-1:0] IMG_Y1     = VW'(IMG_Y + IMG_H);

    // Flag bit positions inside each delay stage.
    localparam int F_ACT   = 0;
    localparam int F_HS    = 1;
    localparam int F_VS    = 2;
    localparam int F_IMG   = 3;
    localparam int F_FIRST = 4;
`ifdef VGA_BORDER_EN
    localparam int F_RING  = 5;
    localparam int NF      = 6;
    localparam logic [HW-1:0] RING_X0 = HW'(IMG_X - 1);
    localparam logic [VW-1:0] RING_Y0 = VW'(IMG_Y - 1);
`else
    localparam int NF      = 5;
`endif

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [HW-1:0]         rel_h;
    logic [VW-1:0]         rel_v;
    logic [ADDR_WIDTH-1:0] img_addr;
    logic [NF-1:0]         flags_now;
    logic [NF-1:0]         pipe [MEM_LATENCY];
    logic [NF-1:0]         last;
    logic [7:0]            pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Every region flag is gated by enable so a disabled scan drains to blanking.
    always_comb begin
        flags_now          = '0;
        flags_now[F_ACT]   = enable && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        flags_now[F_HS]    = enable && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        flags_now[F_VS]    = enable && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        flags_now[F_IMG]   = enable && (h_cnt >= IMG_X0) && (h_cnt < IMG_X1)
                                    && (v_cnt >= IMG_Y0) && (v_cnt < IMG_Y1);
        flags_now[F_FIRST] = enable && (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_BORDER_EN
        flags_now[F_RING]  = enable && (
              ((h_cnt == RING_X0 || h_cnt == IMG_X1) && v_cnt >= RING_Y0 && v_cnt <= IMG_Y1)
           || ((v_cnt == RING_Y0 || v_cnt == IMG_Y1) && h_cnt >= RING_X0 && h_cnt <= IMG_X1));
`endif
    end

    // Constant power-of-two IMG_W reduces this to a bit concatenation.
    assign rel_h    = h_cnt - IMG_X0;
    assign rel_v    = v_cnt - IMG_Y0;
    assign img_addr = ADDR_WIDTH'(32'(rel_v) * IMG_W + 32'(rel_h));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_vga <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
        end else begin
            address_vga <= flags_now[F_IMG] ? img_addr : '0;
            pipe[0]     <= flags_now;
            for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // The last flag stage lines up with the byte the memory returns for this pixel.
    assign last = pipe[MEM_LATENCY-1];

    always_comb begin
        pix = 8'h00;
        if (last[F_ACT]) begin
            if (last[F_IMG]) pix = color;
`ifdef VGA_BORDER_EN
            else if (last[F_RING]) pix = 8'hFF;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            vga_hsync   <= ~last[F_HS];
            vga_vsync   <= ~last[F_VS];
            vga_blank_n <= last[F_ACT];
            vga_r       <= pix;
            vga_g       <= pix;
            vga_b       <= pix;
            frame_start <= last[F_FIRST];
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster so several frames fit in a short run.
// Honours VGA_BORDER_EN the same way the design does.
module tb_vga_frame_reader;

    localparam int TH_ACT  = 40;
    localparam int TH_FP   = 4;
    localparam int TH_SYNC = 8;
    localparam int TH_BP   = 4;
    localparam int TV_ACT  = 30;
    localparam int TV_FP   = 2;
    localparam int TV_SYNC = 2;
    localparam int TV_BP   = 3;
    localparam int IMW     = 16;
    localparam int IMH     = 16;
    localparam int IMX     = 12;
    localparam int IMY     = 7;
    localparam int AW      = 17;
    localparam int LAT     = 1;
    localparam int D       = 1 + LAT;
    localparam int HT      = TH_ACT + TH_FP + TH_SYNC + TH_BP;
    localparam int VT      = TV_ACT + TV_FP + TV_SYNC + TV_BP;
    localparam int FRAME   = HT * VT;
    localparam int W       = 28;
    localparam logic [W-1:0] BLANK = {1'b1, 1'b1, 1'b0, 24'h0, 1'b0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [7:0]    color;
    logic [AW-1:0] address_vga;
    logic          vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
    logic [7:0]    vga_r, vga_g, vga_b;

    logic [7:0]    img_mem [0:(1<<AW)-1];
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] addr_q[$];

    int  checks = 0;
    int  failures = 0;
    int  pos = 0;
    int  cyc = 0;
    bit  in_reset = 1'b1;
    bit  measure_en = 1'b0;
    int  max_addr = 0;

    vga_frame_reader #(
        .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
        .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
        .IMG_W(IMW), .IMG_H(IMH), .IMG_X(IMX), .IMG_Y(IMY),
        .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .color(color),
        .address_vga(address_vga), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    // Framebuffer read port: returns the byte for the address registered on the last edge.
    assign color = img_mem[address_vga];

    // Clock / reset block
    initial forever #5 clk = ~clk;

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
            if (failures >= 40) report();
        end
    endtask

    // Reference model: pixel position -> outputs, straight from the raster rules.
    function automatic bit in_window(int h, int v);
        return h >= IMX && h < IMX + IMW && v >= IMY && v < IMY + IMH;
    endfunction

    function automatic logic [AW-1:0] model_addr(int h, int v, bit e);
        if (e && in_window(h, v)) return AW'((v - IMY) * IMW + (h - IMX));
        return '0;
    endfunction

    function automatic logic [W-1:0] model_out(int h, int v, bit e);
        bit act, hs_n, vs_n, ring, fs;
        logic [7:0] rgb;
        if (!e) return BLANK;
        act  = h < TH_ACT && v < TV_ACT;
        hs_n = !(h >= TH_ACT + TH_FP && h < TH_ACT + TH_FP + TH_SYNC);
        vs_n = !(v >= TV_ACT + TV_FP && v < TV_ACT + TV_FP + TV_SYNC);
        ring = 1'b0;
`ifdef VGA_BORDER_EN
        ring = ((h == IMX - 1 || h == IMX + IMW) && v >= IMY - 1 && v <= IMY + IMH)
            || ((v == IMY - 1 || v == IMY + IMH) && h >= IMX - 1 && h <= IMX + IMW);
`endif
        rgb = 8'h00;
        if (act && in_window(h, v)) rgb = img_mem[model_addr(h, v, 1'b1)];
        else if (act && ring)       rgb = 8'hFF;
        fs = (h == 0 && v == 0);
        return {hs_n, vs_n, act, rgb, rgb, rgb, fs};
    endfunction

    // Driver tasks (called at a falling edge, leave at the next falling edge)
    task automatic step(input bit e);
        int h, v;
        enable = e;
        h = pos % HT;
        v = (pos / HT) % VT;
        exp_q.push_back(model_out(h, v, e));
        addr_q.push_back(model_addr(h, v, e));
        pos = e ? pos + 1 : 0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        in_reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        #1;
        check("reset_async", {address_vga, vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b, frame_start},
              {{AW{1'b0}}, BLANK});
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pos = 0;
        for (int i = 0; i < D - 1; i++) exp_q.push_back(BLANK);
        in_reset = 1'b0;
    endtask

    // Scoreboard monitor plus raster timing measurements
    initial begin
        logic [W-1:0] e_out;
        logic [AW-1:0] e_addr;
        bit prev_hs = 1'b1, prev_vs = 1'b1;
        int hs_fall = -1, vs_fall = -1, fs_last = -1;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!in_reset) begin
                if (exp_q.size() == 0 || addr_q.size() == 0) begin
                    check("queue_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e_out  = exp_q.pop_front();
                    e_addr = addr_q.pop_front();
                    check("pixel_out", 32'({vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b, frame_start}),
                          32'(e_out));
                    check("address", 32'(address_vga), 32'(e_addr));
                end
                if (int'(address_vga) > max_addr) max_addr = int'(address_vga);
                if (measure_en) begin
                    if (prev_hs && !vga_hsync) begin
                        if (hs_fall >= 0) check("hsync_period", 32'(cyc - hs_fall), 32'(HT));
                        hs_fall = cyc;
                    end
                    if (!prev_hs && vga_hsync && hs_fall >= 0) check("hsync_width", 32'(cyc - hs_fall), 32'(TH_SYNC));
                    if (prev_vs && !vga_vsync) begin
                        if (vs_fall >= 0) check("vsync_period", 32'(cyc - vs_fall), 32'(FRAME));
                        vs_fall = cyc;
                    end
                    if (!prev_vs && vga_vsync && vs_fall >= 0) check("vsync_width", 32'(cyc - vs_fall), 32'(TV_SYNC * HT));
                    if (frame_start) begin
                        if (fs_last >= 0) check("frame_period", 32'(cyc - fs_last), 32'(FRAME));
                        fs_last = cyc;
                    end
                end
                prev_hs = vga_hsync;
                prev_vs = vga_vsync;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        failures++;
        report();
    end

    // Stimulus
    initial begin
        int bound;
        for (int i = 0; i < (1 << AW); i++) img_mem[i] = 8'(i < IMW * IMH ? $urandom_range(0, 255) : 0);

        do_reset(3);
        measure_en = 1'b1;
        repeat (2 * FRAME + 200) step(1'b1);
        measure_en = 1'b0;

        // Long disable starting mid-line, then restart from the origin.
        bound = 0;
        while ((pos % HT) != 20 && bound < HT) begin step(1'b1); bound++; end
        repeat (100) step(1'b0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(20, 300)) step(1'b1);
            repeat ($urandom_range(1, 40)) step(1'b0);
        end

        // Reset in the middle of the image window.
        repeat (FRAME + 50) step(1'b1);
        bound = 0;
        while ((pos % FRAME) != 10 * HT + 20 && bound < FRAME) begin step(1'b1); bound++; end
        check("reset_target_reached", 32'(pos % FRAME), 32'(10 * HT + 20));
        do_reset(3);
        repeat (FRAME + 100) step(1'b1);
        repeat (D + 2) step(1'b1);

        check("max_address_bound", 32'(max_addr <= IMW * IMH - 1), 32'd1);
        check("last_address_seen", 32'(max_addr), 32'(IMW * IMH - 1));
        check("sync_n_tied", 32'(vga_sync_n), 32'd0);
        report();
    end

endmodule
